// File: rtl/serial_io_ctrl.sv
// Memory-mapped serial byte I/O controller: RX/TX FIFOs, DATA/STATUS/CTRL registers, rden/wren handshake FSMs.
// Optional build macro SERIAL_IO_LOOPBACK_EN adds CTRL[3] loopback (TX head moved straight into RX).
module serial_io_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_sel,
  input  logic [1:0]  io_addr,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [7:0]  serial_in,
  input  logic        serial_valid_in,
  input  logic        serial_ready_in,
  output logic [7:0]  serial_out,
  output logic        serial_rden_out,
  output logic        serial_wren_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_HOLD} tx_state_t;

  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [PTR_W-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [CNT_W-1:0] rx_count_reg, tx_count_reg;

  logic      rx_en_reg, tx_en_reg;
  logic      tx_drop_reg, rx_underflow_reg;
  rx_state_t rx_state_reg;
  tx_state_t tx_state_reg;
  logic [7:0] serial_out_reg;
  logic      rden_reg, wren_reg;

  logic       loopback;
  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic       data_rd, data_wr, ctrl_wr, clr_err;
  logic       rx_cap, tx_fire, loop_active;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rx_push_data;
  logic [31:0] status_word;
  logic       unused_wdata;

  assign unused_wdata = ^io_wdata[31:3];

`ifdef SERIAL_IO_LOOPBACK_EN
  logic loopback_reg;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      loopback_reg <= 1'b0;
    else if (ctrl_wr)
      loopback_reg <= io_wdata[3];
  end
  assign loopback = loopback_reg;
`else
  assign loopback = 1'b0;
`endif

  assign rx_full  = (rx_count_reg == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_count_reg == '0);
  assign tx_full  = (tx_count_reg == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (tx_count_reg == '0);
  assign rx_head  = rx_mem[rx_rd_ptr_reg];
  assign tx_head  = tx_mem[tx_rd_ptr_reg];

  assign data_rd = io_sel & io_rd & (io_addr == 2'd0);
  assign data_wr = io_sel & io_wr & (io_addr == 2'd0);
  assign ctrl_wr = io_sel & io_wr & (io_addr == 2'd2);
  assign clr_err = ctrl_wr & io_wdata[2];

  // In loopback the RX FSM is parked and the TX FSM becomes the only RX producer.
  assign loop_active  = loopback;
  assign rx_cap       = (rx_state_reg == RX_IDLE) & ~loop_active & rx_en_reg & serial_valid_in & ~rx_full;
  assign tx_fire      = (tx_state_reg == TX_IDLE) & tx_en_reg & ~tx_empty &
                        (loop_active ? ~rx_full : serial_ready_in);
  assign rx_push      = rx_cap | (tx_fire & loop_active);
  assign rx_push_data = loop_active ? tx_head : serial_in;
  assign rx_pop       = data_rd & ~rx_empty;
  assign tx_push      = data_wr & ~tx_full;
  assign tx_pop       = tx_fire;

  // Storage arrays carry no reset; validity is tracked by the counts.
  always_ff @(posedge clock) begin
    if (rx_push)
      rx_mem[rx_wr_ptr_reg] <= rx_push_data;
    if (tx_push)
      tx_mem[tx_wr_ptr_reg] <= io_wdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_W'(1);
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + CNT_W'(1);
        2'b01:   rx_count_reg <= rx_count_reg - CNT_W'(1);
        default: rx_count_reg <= rx_count_reg;
      endcase
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + CNT_W'(1);
        2'b01:   tx_count_reg <= tx_count_reg - CNT_W'(1);
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_en_reg        <= 1'b1;
      tx_en_reg        <= 1'b1;
      tx_drop_reg      <= 1'b0;
      rx_underflow_reg <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_en_reg <= io_wdata[0];
        tx_en_reg <= io_wdata[1];
      end
      if (data_wr & tx_full)
        tx_drop_reg <= 1'b1;
      else if (clr_err)
        tx_drop_reg <= 1'b0;
      if (data_rd & rx_empty)
        rx_underflow_reg <= 1'b1;
      else if (clr_err)
        rx_underflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      rden_reg     <= 1'b0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: if (rx_cap) begin
          rden_reg     <= 1'b1;
          rx_state_reg <= RX_HOLD;
        end
        RX_HOLD: begin
          rden_reg     <= 1'b0;
          rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_reg   <= TX_IDLE;
      serial_out_reg <= 8'd0;
      wren_reg       <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: if (tx_fire) begin
          tx_state_reg <= TX_HOLD;
          if (!loop_active) begin
            serial_out_reg <= tx_head;
            wren_reg       <= 1'b1;
          end
        end
        TX_HOLD: begin
          wren_reg     <= 1'b0;
          tx_state_reg <= TX_IDLE;
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[0]             = ~rx_empty;
    status_word[1]             = tx_full;
    status_word[2]             = tx_drop_reg;
    status_word[3]             = rx_underflow_reg;
    status_word[8 +: CNT_W]    = rx_count_reg;
    status_word[16 +: CNT_W]   = tx_count_reg;
  end

  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      case (io_addr)
        2'd0:    io_rdata = {24'd0, rx_empty ? 8'd0 : rx_head};
        2'd1:    io_rdata = status_word;
        2'd2:    io_rdata = {28'd0, loopback, 1'b0, tx_en_reg, rx_en_reg};
        default: io_rdata = '0;
      endcase
    end
  end

  assign serial_out      = serial_out_reg;
  assign serial_rden_out = rden_reg;
  assign serial_wren_out = wren_reg;

endmodule

// File: tb/tb_serial_io_ctrl.sv
// Self-checking bench for serial_io_ctrl: TX bytes go through a scoreboard queue checked on each wren pulse.
module tb_serial_io_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        io_sel, io_rd, io_wr;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic [7:0]  serial_in, serial_out;
  logic        serial_valid_in, serial_ready_in;
  logic        serial_rden_out, serial_wren_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] tx_sb[$];
  int wren_cyc[$];

  serial_io_ctrl #(.FIFO_DEPTH(4), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .io_sel(io_sel), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
    .serial_in(serial_in), .serial_valid_in(serial_valid_in), .serial_ready_in(serial_ready_in),
    .serial_out(serial_out), .serial_rden_out(serial_rden_out), .serial_wren_out(serial_wren_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else
      $display("ok   %s: 0x%08h", tag, got);
  endtask

  // TX monitor: every wren pulse must carry the oldest byte the bench queued.
  always @(negedge clock) begin
    if (!reset && serial_wren_out) begin
      wren_cyc.push_back(cyc);
      if (tx_sb.size() == 0)
        check("tx_sb_nonempty", 32'(tx_sb.size()), 32'd1);
      else
        check("tx_byte", 32'(serial_out), 32'(tx_sb.pop_front()));
    end
  end

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock);
    io_sel = 1'b1; io_rd = 1'b1; io_wr = 1'b0; io_addr = a;
    #1 d = io_rdata;
    @(posedge clock);
    #1 io_sel = 1'b0; io_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clock);
    io_sel = 1'b1; io_wr = 1'b1; io_rd = 1'b0; io_addr = a; io_wdata = v;
    @(posedge clock);
    #1 io_sel = 1'b0; io_wr = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int n;
    logic got;
    reset = 1'b1; io_sel = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_wdata = '0;
    serial_in = 8'd0; serial_valid_in = 1'b0; serial_ready_in = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_serial_out", 32'(serial_out), 32'd0);
    check("rst_rden", 32'(serial_rden_out), 32'd0);
    check("rst_wren", 32'(serial_wren_out), 32'd0);
    reset = 1'b0;
    cpu_read(2'd1, d); check("rst_status", d, 32'h0);
    cpu_read(2'd2, d); check("rst_ctrl", d, 32'h3);

    // 1: single capture, rden one cycle after the capture edge
    @(negedge clock); serial_in = 8'hAA; serial_valid_in = 1'b1;
    @(negedge clock); check("t1_rden_hi", 32'(serial_rden_out), 32'd1); serial_valid_in = 1'b0;
    @(negedge clock); check("t1_rden_lo", 32'(serial_rden_out), 32'd0);
    cpu_read(2'd1, d); check("t1_status", d, 32'h0000_0101);
    cpu_read(2'd0, d); check("t1_data", d, 32'h0000_00AA);
    cpu_read(2'd1, d); check("t1_status_empty", d, 32'h0);

    // 2: two transmits, two cycles apart
    serial_ready_in = 1'b1; wren_cyc.delete();
    tx_sb.push_back(8'h41); cpu_write(2'd0, 32'h41);
    tx_sb.push_back(8'h42); cpu_write(2'd0, 32'h42);
    wait_cycles(6);
    check("t2_wren_count", 32'(wren_cyc.size()), 32'd2);
    if (wren_cyc.size() >= 2) check("t2_wren_gap", 32'(wren_cyc[1] - wren_cyc[0]), 32'd2);
    cpu_read(2'd1, d); check("t2_status", d, 32'h0);

    // 3: overfill TX while device not ready
    serial_ready_in = 1'b0; wren_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_sb.push_back(8'(8'h10 + i));
      cpu_write(2'd0, 32'h10 + i);
    end
    cpu_read(2'd1, d); check("t3_status_full", d, 32'h0004_0006);
    check("t3_no_wren", 32'(wren_cyc.size()), 32'd0);
    @(negedge clock); serial_ready_in = 1'b1;
    wait_cycles(12);
    check("t3_wren_count", 32'(wren_cyc.size()), 32'd4);
    check("t3_sb_drained", 32'(tx_sb.size()), 32'd0);
    cpu_write(2'd2, 32'h7);
    cpu_read(2'd1, d); check("t3_status_clr", d, 32'h0);
    cpu_read(2'd2, d); check("t3_ctrl", d, 32'h3);

    // 4: RX backpressure with valid held high
    @(negedge clock); serial_in = 8'h60; serial_valid_in = 1'b1; n = 0;
    repeat (16) begin
      @(negedge clock);
      if (serial_rden_out) begin n++; serial_in = serial_in + 8'd1; end
    end
    check("t4_captures", n, 4);
    cpu_read(2'd1, d); check("t4_status_full", d, 32'h0000_0401);
    cpu_read(2'd0, d); check("t4_data0", d, 32'h60);
    n = 0;
    repeat (8) begin
      @(negedge clock);
      if (serial_rden_out) begin n++; serial_in = serial_in + 8'd1; end
    end
    serial_valid_in = 1'b0;
    check("t4_refill", n, 1);
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'd0, d); check("t4_data", d, 32'h61 + i);
    end
    cpu_read(2'd1, d); check("t4_status_empty", d, 32'h0);

    // 5: underflow, then simultaneous pop and capture
    cpu_read(2'd0, d); check("t5_underflow_data", d, 32'h0);
    cpu_read(2'd1, d); check("t5_underflow_flag", d, 32'h8);
    cpu_write(2'd2, 32'h7);
    @(negedge clock); serial_in = 8'h77; serial_valid_in = 1'b1;
    @(negedge clock); check("t5_rden", 32'(serial_rden_out), 32'd1); serial_valid_in = 1'b0;
    @(negedge clock);
    serial_in = 8'h78; serial_valid_in = 1'b1;
    io_sel = 1'b1; io_rd = 1'b1; io_addr = 2'd0;
    #1 check("t5_same_cycle_rd", io_rdata, 32'h77);
    @(posedge clock);
    #1 io_sel = 1'b0; io_rd = 1'b0;
    @(negedge clock); check("t5_rden2", 32'(serial_rden_out), 32'd1); serial_valid_in = 1'b0;
    cpu_read(2'd1, d); check("t5_count_kept", d, 32'h0000_0101);
    cpu_read(2'd0, d); check("t5_data", d, 32'h78);

    // 6: loopback control, then reset mid-transfer
    cpu_write(2'd2, 32'hB);
    serial_ready_in = 1'b1; wren_cyc.delete();
`ifdef SERIAL_IO_LOOPBACK_EN
    cpu_read(2'd2, d); check("t6_ctrl", d, 32'hB);
    cpu_write(2'd0, 32'h55);
    wait_cycles(6);
    check("t6_no_wren", 32'(wren_cyc.size()), 32'd0);
    check("t6_serial_out_kept", 32'(serial_out), 32'h13);
    cpu_read(2'd0, d); check("t6_loop_data", d, 32'h55);
`else
    cpu_read(2'd2, d); check("t6_ctrl", d, 32'h3);
    tx_sb.push_back(8'h55); cpu_write(2'd0, 32'h55);
    wait_cycles(6);
    check("t6_wren_count", 32'(wren_cyc.size()), 32'd1);
    cpu_read(2'd1, d); check("t6_status", d, 32'h0);
`endif
    cpu_write(2'd2, 32'h3);
    tx_sb.push_back(8'h99); cpu_write(2'd0, 32'h99);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clock);
      if (serial_wren_out) got = 1'b1;
    end
    check("t6_wren_seen", 32'(got), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_serial_out", 32'(serial_out), 32'd0);
    check("t6_rst_wren", 32'(serial_wren_out), 32'd0);
    check("t6_rst_rden", 32'(serial_rden_out), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cpu_read(2'd1, d); check("t6_rst_status", d, 32'h0);
    cpu_read(2'd2, d); check("t6_rst_ctrl", d, 32'h3);

    check("sb_empty", 32'(tx_sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
